rf_wb_arbiter: RTL and testbench
================================

// Module: rf_wb_arbiter
// PURPOSE
//  Owns the single RegisterFile write port (RegWrite/rd/RegWriteData). Shares it between the
//  pipeline WB stage (fixed priority) and a multi-cycle unit (div/mul/load-miss) via a 1-entry
//  holding buffer. Keeps a busy scoreboard of registers with pending multi-cycle writes and
//  raises a decode stall on RAW/WAW. Sits between WB, the multi-cycle unit and RegisterFile.
// PARAMETERS
//  XLEN        32  data width
//  REG_AW      5   register index width (32 registers, x0 hard-wired zero)
//  STARVE_MAX  8   cycles the hold buffer may wait before decode is forced to stall
// PORTS
//  clk          in   1       clock, all state on posedge
//  reset        in   1       synchronous, active-high
//  wb_we        in   1       WB stage write request (never back-pressured)
//  wb_rd        in   REG_AW  WB destination
//  wb_data      in   XLEN    WB result
//  mc_valid     in   1       multi-cycle result valid
//  mc_rd        in   REG_AW  multi-cycle destination
//  mc_data      in   XLEN    multi-cycle result
//  mc_ready     out  1       hold buffer can accept
//  dec_valid    in   1       decode holds a real instruction
//  dec_rs1      in   REG_AW  decode source 1
//  dec_rs2      in   REG_AW  decode source 2
//  dec_rd       in   REG_AW  decode destination
//  mc_issue     in   1       decode issues multi-cycle op writing dec_rd
//  dec_stall    out  1       freeze decode/fetch
//  RegWrite     out  1       to RegisterFile
//  rd           out  REG_AW  to RegisterFile
//  RegWriteData out  XLEN    to RegisterFile
//  busy_vec     out  2^REG_AW  scoreboard (debug/forwarding)
// BEHAVIOUR
//  Reset (sync): hold empty, busy_vec=0, starve_cnt=0. While reset=1, RegWrite=0 and mc_ready=0.
//  Hold FSM (2 states): EMPTY -> FULL on mc_valid&&mc_ready&&mc_rd!=0;
//   FULL -> EMPTY on the cycle the hold entry drives the port. mc_ready = (state==EMPTY).
//   mc_valid with mc_rd==0: handshake completes, data discarded, stays EMPTY.
//  Port mux (combinational): wb_we&&wb_rd!=0 -> WB drives port. Else, if FULL -> hold drives port.
//   Else RegWrite=0. WB to x0 leaves the port free for the hold entry.
//  Latency: mc accepted at edge N -> port driven in cycle N+1 if WB is idle -> RF updated at edge N+2.
//  No accept-and-drain in the same cycle: EMPTY->FULL->EMPTY takes >=2 cycles, so throughput is 1/2.
//  Scoreboard: busy[r] set at edge when mc_issue&&!dec_stall&&dec_rd!=0 (r=dec_rd).
//   busy[r] cleared at the edge where the hold entry for r is written. A set and clear of the same
//   r in one cycle: set wins. busy[0] is always 0. mc_issue while dec_stall=1 is ignored.
//  dec_stall = dec_valid && (busy[dec_rs1]|busy[dec_rs2]|busy[dec_rd]) || starve.
//   No bypass from hold to decode: the stall holds until the write edge, so the next read sees RF.
//  Starvation: starve_cnt increments each cycle the state is FULL and the port is taken by WB.
//   It clears on drain or reset and saturates at STARVE_MAX. starve = (starve_cnt==STARVE_MAX).
//   The resulting bubbles reach WB and free the port.
//  WB write to a busy register cannot occur (WAW stall). Contract violations are not detected.
// STRUCTURE
//  Package rv_pkg: XLEN, REG_AW, NREG=32, X0=5'd0, hold state enum {HOLD_EMPTY, HOLD_FULL}.
//  Sub-module rf_scoreboard: busy_vec reg, set/clear ports, 3 read ports -> hazard bit.
//  Top: hold FSM, starve counter, port mux.
// TESTING
//  1 reset mid-FULL (hold x5=0xDEAD) -> next cycle RegWrite=0, busy_vec=0, mc_ready=1 (post-reset).
//  2 WB idle, mc x7=0x1234 at N -> RegWrite=1, rd=7, data=0x1234 in N+1; busy[7] clears at edge N+2.
//  3 WB writes every cycle while hold FULL -> port always WB. After 8 cycles dec_stall=1.
//    First wb_we=0 cycle drains the hold and starve_cnt=0.
//  4 issue x3 then decode rs2=3 -> dec_stall=1 until the hold-x3 write edge, then 0 the next cycle.
//  5 WB wb_rd=0 with wb_we=1 while hold FULL (x9) -> hold drives port: rd=9.
//    mc_rd=0 result -> mc_ready stays 1, no write.
//  6 mc_issue x4 in the same cycle busy[4] clears -> busy[4]=1 after the edge.
//    mc_issue while dec_stall=1 -> no busy change.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
//   XLEN   : datapath width
//   REG_AW : register index width
//   NREG   : number of architectural registers
//   X0     : hard-wired zero register index
//   hold_state_e : occupancy of the 1-entry multi-cycle holding buffer
package rv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned NREG   = 32;
  localparam logic [4:0]  X0     = 5'd0;

  typedef enum logic [0:0] {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard for registers that have a multi-cycle write in flight.
//   clk, reset           : clock, synchronous active-high reset
//   set_en, set_idx      : mark a register busy at the next edge
//   clr_en, clr_idx      : mark a register free at the next edge
//   rd_idx0/1/2          : three lookup indices (rs1, rs2, rd of decode)
//   hazard               : any looked-up register is busy
//   busy_vec             : full busy vector
module rf_scoreboard
  import rv_pkg::*;
#(
  parameter int unsigned AW = REG_AW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                set_en,
  input  logic [AW-1:0]       set_idx,
  input  logic                clr_en,
  input  logic [AW-1:0]       clr_idx,
  input  logic [AW-1:0]       rd_idx0,
  input  logic [AW-1:0]       rd_idx1,
  input  logic [AW-1:0]       rd_idx2,
  output logic                hazard,
  output logic [(1<<AW)-1:0]  busy_vec
);

  logic [(1<<AW)-1:0] busy_q;
  logic [(1<<AW)-1:0] busy_d;

  // Clear is applied before set so that a new issue to a register whose
  // previous result is landing this cycle keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    if (set_en) busy_d[set_idx] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign hazard   = busy_q[rd_idx0] | busy_q[rd_idx1] | busy_q[rd_idx2];
  assign busy_vec = busy_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Owns the single register-file write port. The WB stage always wins; a
// multi-cycle result waits in a 1-entry hold buffer until the port is free.
// A busy scoreboard stalls decode on RAW/WAW against pending multi-cycle
// writes, and a starvation counter forces decode bubbles so WB eventually
// leaves a free slot for the hold entry.
//   clk, reset                 : clock, synchronous active-high reset
//   wb_we/wb_rd/wb_data        : WB stage write request
//   mc_valid/mc_rd/mc_data     : multi-cycle result, mc_ready handshake
//   dec_valid/dec_rs1/rs2/rd   : decode operands for hazard lookup
//   mc_issue                   : decode issues a multi-cycle op to dec_rd
//   dec_stall                  : freeze decode/fetch
//   RegWrite/rd/RegWriteData   : register-file write port
//   busy_vec                   : scoreboard contents
//
//   state      | meaning
//   HOLD_EMPTY | hold buffer free, mc_ready=1
//   HOLD_FULL  | hold buffer waiting for a free port cycle
module rf_wb_arbiter
  import rv_pkg::*;
#(
  parameter int unsigned XLEN_P     = XLEN,
  parameter int unsigned REG_AW_P   = REG_AW,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wb_we,
  input  logic [REG_AW_P-1:0]       wb_rd,
  input  logic [XLEN_P-1:0]         wb_data,
  input  logic                      mc_valid,
  input  logic [REG_AW_P-1:0]       mc_rd,
  input  logic [XLEN_P-1:0]         mc_data,
  output logic                      mc_ready,
  input  logic                      dec_valid,
  input  logic [REG_AW_P-1:0]       dec_rs1,
  input  logic [REG_AW_P-1:0]       dec_rs2,
  input  logic [REG_AW_P-1:0]       dec_rd,
  input  logic                      mc_issue,
  output logic                      dec_stall,
  output logic                      RegWrite,
  output logic [REG_AW_P-1:0]       rd,
  output logic [XLEN_P-1:0]         RegWriteData,
  output logic [(1<<REG_AW_P)-1:0]  busy_vec
);

  localparam int unsigned SCW = $clog2(STARVE_MAX + 1);

  hold_state_e          state_q, state_d;
  logic [REG_AW_P-1:0]  hold_rd_q, hold_rd_d;
  logic [XLEN_P-1:0]    hold_data_q, hold_data_d;
  logic [SCW-1:0]       starve_cnt_q, starve_cnt_d;

  logic wb_port;
  logic hold_full;
  logic hold_drain;
  logic mc_accept;
  logic starve;
  logic hazard;
  logic issue_en;

  // A WB write to x0 is a no-op and leaves the slot to the hold entry.
  assign wb_port    = wb_we && (wb_rd != '0);
  assign hold_full  = (state_q == HOLD_FULL);
  assign hold_drain = !reset && hold_full && !wb_port;
  assign mc_ready   = !reset && (state_q == HOLD_EMPTY);
  assign mc_accept  = mc_valid && mc_ready && (mc_rd != '0);

  always_comb begin
    RegWrite     = 1'b0;
    rd           = '0;
    RegWriteData = '0;
    if (!reset) begin
      if (wb_port) begin
        RegWrite     = 1'b1;
        rd           = wb_rd;
        RegWriteData = wb_data;
      end else if (hold_full) begin
        RegWrite     = 1'b1;
        rd           = hold_rd_q;
        RegWriteData = hold_data_q;
      end
    end
  end

  // No accept-and-drain in one cycle: accept only happens from EMPTY and
  // drain only from FULL.
  always_comb begin
    state_d     = state_q;
    hold_rd_d   = hold_rd_q;
    hold_data_d = hold_data_q;
    case (state_q)
      HOLD_EMPTY: begin
        if (mc_accept) begin
          state_d     = HOLD_FULL;
          hold_rd_d   = mc_rd;
          hold_data_d = mc_data;
        end
      end
      HOLD_FULL: begin
        if (hold_drain) state_d = HOLD_EMPTY;
      end
      default: state_d = HOLD_EMPTY;
    endcase
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (hold_drain) begin
      starve_cnt_d = '0;
    end else if (hold_full && wb_port && (starve_cnt_q != SCW'(STARVE_MAX))) begin
      starve_cnt_d = starve_cnt_q + SCW'(1);
    end
  end

  assign starve = (starve_cnt_q == SCW'(STARVE_MAX));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= HOLD_EMPTY;
      hold_rd_q    <= '0;
      hold_data_q  <= '0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      hold_rd_q    <= hold_rd_d;
      hold_data_q  <= hold_data_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign dec_stall = (dec_valid && hazard) || starve;
  assign issue_en  = mc_issue && !dec_stall && (dec_rd != '0);

  rf_scoreboard #(
    .AW (REG_AW_P)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .set_en   (issue_en),
    .set_idx  (dec_rd),
    .clr_en   (hold_drain),
    .clr_idx  (hold_rd_q),
    .rd_idx0  (dec_rs1),
    .rd_idx1  (dec_rs2),
    .rd_idx2  (dec_rd),
    .hazard   (hazard),
    .busy_vec (busy_vec)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: hand-computed expectations per scenario.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mc_valid;
  logic [4:0]  mc_rd;
  logic [31:0] mc_data;
  logic        mc_ready;
  logic        dec_valid;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        mc_issue;
  logic        dec_stall;
  logic        RegWrite;
  logic [4:0]  rd;
  logic [31:0] RegWriteData;
  logic [31:0] busy_vec;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .wb_we        (wb_we),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .mc_valid     (mc_valid),
    .mc_rd        (mc_rd),
    .mc_data      (mc_data),
    .mc_ready     (mc_ready),
    .dec_valid    (dec_valid),
    .dec_rs1      (dec_rs1),
    .dec_rs2      (dec_rs2),
    .dec_rd       (dec_rd),
    .mc_issue     (mc_issue),
    .dec_stall    (dec_stall),
    .RegWrite     (RegWrite),
    .rd           (rd),
    .RegWriteData (RegWriteData),
    .busy_vec     (busy_vec)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven here, away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs.
  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    wb_we = 0; wb_rd = 0; wb_data = 0;
    mc_valid = 0; mc_rd = 0; mc_data = 0;
    dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
    mc_issue = 0;
  endtask

  task automatic issue(input logic [4:0] r);
    idle_inputs();
    dec_valid = 1; dec_rd = r; mc_issue = 1;
    tick();
    idle_inputs();
  endtask

  task automatic fill_hold(input logic [4:0] r, input logic [31:0] d);
    idle_inputs();
    mc_valid = 1; mc_rd = r; mc_data = d;
    tick();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    wb_we = 1; wb_rd = 5'd2; mc_valid = 1; mc_rd = 5'd3;
    settle();
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_mc_ready", mc_ready, 0);
    tick();
    tick();
    reset = 0;
    idle_inputs();
    settle();
    chk("post_rst_busy", busy_vec, 0);
    chk("post_rst_ready", mc_ready, 1);

    // mc write latency with WB idle
    dec_valid = 1; dec_rd = 5'd7; mc_issue = 1;
    settle();
    chk("t2_issue_nostall", dec_stall, 0);
    tick();
    idle_inputs();
    chk("t2_busy7_set", busy_vec, 32'h0000_0080);
    mc_valid = 1; mc_rd = 5'd7; mc_data = 32'h1234;
    settle();
    chk("t2_ready_N", mc_ready, 1);
    chk("t2_nowrite_N", RegWrite, 0);
    tick();
    idle_inputs();
    settle();
    chk("t2_we_N1", RegWrite, 1);
    chk("t2_rd_N1", rd, 7);
    chk("t2_data_N1", RegWriteData, 32'h1234);
    chk("t2_busy_N1", busy_vec, 32'h0000_0080);
    chk("t2_ready_N1", mc_ready, 0);
    tick();
    chk("t2_busy_N2", busy_vec, 0);
    chk("t2_we_N2", RegWrite, 0);
    chk("t2_ready_N2", mc_ready, 1);

    // RAW stall until the hold write edge
    issue(5'd3);
    dec_valid = 1; dec_rs2 = 5'd3; dec_rd = 5'd10;
    settle();
    chk("t4_stall0", dec_stall, 1);
    tick();
    chk("t4_stall1", dec_stall, 1);
    mc_valid = 1; mc_rd = 5'd3; mc_data = 32'h33;
    tick();
    mc_valid = 0;
    settle();
    chk("t4_stall_drain", dec_stall, 1);
    chk("t4_rd_drain", rd, 3);
    tick();
    chk("t4_stall_after", dec_stall, 0);
    idle_inputs();

    // WB to x0 leaves port to hold; mc to x0 discarded
    issue(5'd9);
    fill_hold(5'd9, 32'h99);
    wb_we = 1; wb_rd = 5'd0; wb_data = 32'h5555;
    settle();
    chk("t5_we", RegWrite, 1);
    chk("t5_rd", rd, 9);
    chk("t5_data", RegWriteData, 32'h99);
    tick();
    idle_inputs();
    chk("t5_busy_clr", busy_vec, 0);
    mc_valid = 1; mc_rd = 5'd0; mc_data = 32'hABCD;
    settle();
    chk("t5_x0_ready_pre", mc_ready, 1);
    tick();
    idle_inputs();
    settle();
    chk("t5_x0_ready", mc_ready, 1);
    chk("t5_x0_nowrite", RegWrite, 0);

    // Starvation: WB owns the port every cycle while hold is FULL
    issue(5'd11);
    fill_hold(5'd11, 32'hB);
    for (int i = 0; i < 8; i++) begin
      wb_we = 1; wb_rd = 5'(i + 1); wb_data = 32'(100 + i);
      settle();
      chk($sformatf("t3_rd_%0d", i), rd, 64'(i + 1));
      chk($sformatf("t3_nostall_%0d", i), dec_stall, 0);
      tick();
    end
    wb_we = 1; wb_rd = 5'd20; wb_data = 32'h20;
    settle();
    chk("t3_stall_8", dec_stall, 1);
    chk("t3_rd_wb", rd, 20);
    tick();
    chk("t3_stall_sat", dec_stall, 1);
    wb_we = 0;
    settle();
    chk("t3_drain_rd", rd, 11);
    chk("t3_drain_data", RegWriteData, 32'hB);
    tick();
    chk("t3_stall_clr", dec_stall, 0);
    chk("t3_busy_clr", busy_vec, 0);
    chk("t3_ready", mc_ready, 1);

    // Set wins over clear on the same register
    issue(5'd4);
    fill_hold(5'd4, 32'h44);
    mc_issue = 1; dec_rd = 5'd4; dec_valid = 0;
    settle();
    chk("t6_drain_rd", rd, 4);
    tick();
    idle_inputs();
    chk("t6_set_wins", busy_vec, 32'h0000_0010);
    dec_valid = 1; dec_rs1 = 5'd4; dec_rd = 5'd12; mc_issue = 1;
    settle();
    chk("t6_stalled", dec_stall, 1);
    tick();
    idle_inputs();
    chk("t6_ignored_issue", busy_vec, 32'h0000_0010);

    // Reset while hold is FULL
    reset = 1;
    tick();
    reset = 0;
    issue(5'd5);
    fill_hold(5'd5, 32'hDEAD);
    wb_we = 1; wb_rd = 5'd2;
    reset = 1;
    settle();
    chk("t1_rst_we", RegWrite, 0);
    chk("t1_rst_ready", mc_ready, 0);
    tick();
    reset = 0;
    idle_inputs();
    settle();
    chk("t1_post_we", RegWrite, 0);
    chk("t1_post_busy", busy_vec, 0);
    chk("t1_post_ready", mc_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
